// File: rtl/path_delay_meter.sv
// Purpose: launch/capture controller measuring spypath chain delay over a burst of rising/falling trials.
// Latency: per edge SETTLE_CYC + 1 + measured delay cycles; done pulses one cycle after the final match or a timeout.
// Backpressure: none; start is accepted only in IDLE, and start while busy or during DONE is dropped.
module path_delay_meter #(
  parameter int CNT_W       = 16,
  parameter int TRIALS_LOG2 = 3,
  parameter int TIMEOUT     = 1000,
  parameter int SETTLE_CYC  = 16,
  parameter int PATH_INV    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         pathInput,
  input  logic                         pathResult,
  output logic                         busy,
  output logic                         done,
  output logic                         timeout,
  output logic [CNT_W+TRIALS_LOG2:0]   delaySum,
  output logic [CNT_W-1:0]             delayMax
);

  localparam int SUM_W  = CNT_W + TRIALS_LOG2 + 1;
  localparam int EDGE_W = TRIALS_LOG2 + 1;

  // Edge counter is exactly wide enough that its all-ones value is the final edge.
  localparam logic [EDGE_W-1:0] LAST_EDGE   = '1;
  localparam logic [CNT_W-1:0]  TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic              INV_BIT     = (PATH_INV != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                rs1;
  logic                rs2;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [EDGE_W-1:0]   edgeCnt;

  logic                match;
  logic                settle_end;
  logic                last_edge;
  logic                timeout_hit;

  assign cnt_inc     = cnt + 1'b1;
  assign match       = (rs2 == (pathInput ^ INV_BIT));
  assign settle_end  = (cnt == SETTLE_LAST);
  assign last_edge   = (edgeCnt == LAST_EDGE);
  assign timeout_hit = (cnt_inc == TIMEOUT_C);

  // Two-flop synchroniser for the chain output, which is asynchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1 <= 1'b0;
      rs2 <= 1'b0;
    end else begin
      rs1 <= pathResult;
      rs2 <= rs1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (settle_end) begin
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (match) begin
          state_nxt = last_edge ? S_DONE : S_SETTLE;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Launch, counting and result accumulation. pathInput flips on the edge
  // that enters LAUNCH, so the LAUNCH cycle is already the first cycle of the
  // new level; a zero-delay chain then matches two edges later through the
  // synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pathInput <= 1'b0;
      timeout   <= 1'b0;
      delaySum  <= '0;
      delayMax  <= '0;
      cnt       <= '0;
      edgeCnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            timeout  <= 1'b0;
            delaySum <= '0;
            delayMax <= '0;
            cnt      <= '0;
            edgeCnt  <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_end) begin
            pathInput <= ~pathInput;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_LAUNCH: begin
          cnt <= '0;
        end
        S_WAIT: begin
          if (match) begin
            delaySum <= delaySum + SUM_W'(cnt_inc);
            if (cnt_inc > delayMax) begin
              delayMax <= cnt_inc;
            end
            edgeCnt <= edgeCnt + 1'b1;
            cnt     <= '0;
          end else if (timeout_hit) begin
            // Partial count of an aborted edge is deliberately not accumulated.
            timeout <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DONE: begin
          // Return to the baseline so the next burst starts with a rising edge.
          pathInput <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_meter.sv
module tb_path_delay_meter;

  localparam int CNT_W = 16;
  localparam int TL    = 1;
  localparam int TO    = 20;
  localparam int SC    = 16;
  localparam int SUM_W = CNT_W + TL + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic             p_in;
  logic             p_res;
  logic             busy;
  logic             done;
  logic             to;
  logic [SUM_W-1:0] dsum;
  logic [CNT_W-1:0] dmax;

  logic             start_i;
  logic             p_in_i;
  logic             p_res_i;
  logic             busy_i;
  logic             done_i;
  logic             to_i;
  logic [SUM_W-1:0] dsum_i;
  logic [CNT_W-1:0] dmax_i;

  // Chain model: 0 loopback, 1 rise delayed 5 / fall delayed 3, 2 stuck at 0, 3 stuck at 1
  int         mode;
  logic [7:0] hist = '0;

  always @(posedge clk) hist <= {hist[6:0], p_in};

  always_comb begin
    p_res = 1'b0;
    if (mode == 0)      p_res = p_in;
    else if (mode == 1) p_res = hist[4] & hist[2];
    else if (mode == 3) p_res = 1'b1;
    else                p_res = 1'b0;
  end

  assign p_res_i = ~p_in_i;

  path_delay_meter #(.CNT_W(CNT_W), .TRIALS_LOG2(TL), .TIMEOUT(TO), .SETTLE_CYC(SC), .PATH_INV(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pathInput(p_in), .pathResult(p_res),
    .busy(busy), .done(done), .timeout(to), .delaySum(dsum), .delayMax(dmax)
  );

  path_delay_meter #(.CNT_W(CNT_W), .TRIALS_LOG2(TL), .TIMEOUT(TO), .SETTLE_CYC(SC), .PATH_INV(1)) u_inv (
    .clk(clk), .rst_n(rst_n), .start(start_i), .pathInput(p_in_i), .pathResult(p_res_i),
    .busy(busy_i), .done(done_i), .timeout(to_i), .delaySum(dsum_i), .delayMax(dmax_i)
  );

  typedef struct {
    int mode;
    int sum;
    int max;
    int to;
  } vec_t;

  typedef struct {
    int sum;
    int max;
    int to;
  } exp_t;

  vec_t tbl[5];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit inv);
    @(negedge clk);
    if (inv) start_i = 1'b1;
    else     start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input bit inv, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (inv ? done_i : done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", {31'b0, ok}, 32'd1);
  endtask

  // Pop the expected record and compare against the result present while done is high.
  task automatic check_result(input bit inv, input bit ok);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sbq.pop_front();
    if (!ok) return;
    chk("delay_sum", 32'(inv ? dsum_i : dsum), e.sum);
    chk("delay_max", 32'(inv ? dmax_i : dmax), e.max);
    chk("timeout",   32'(inv ? to_i : to), e.to);
    @(negedge clk);
    chk("busy_after_done",   32'(inv ? busy_i : busy), 0);
    chk("done_width",        32'(inv ? done_i : done), 0);
    chk("pathinput_baseline", 32'(inv ? p_in_i : p_in), 0);
    chk("sum_stable",        32'(inv ? dsum_i : dsum), e.sum);
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    mode = v.mode;
    sbq.push_back('{v.sum, v.max, v.to});
    pulse_start(1'b0);
    chk("busy_after_start", 32'(busy), 1);
    wait_done(1'b0, ok);
    check_result(1'b0, ok);
  endtask

  initial begin
    bit ok;
    tbl[0] = '{0,  8, 2, 0};
    tbl[1] = '{1, 24, 7, 0};
    tbl[2] = '{2,  0, 0, 1};
    tbl[3] = '{0,  8, 2, 0};
    tbl[4] = '{1, 24, 7, 0};

    mode    = 0;
    start   = 1'b0;
    start_i = 1'b0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_to",    32'(to), 0);
    chk("rst_sum",   32'(dsum), 0);
    chk("rst_max",   32'(dmax), 0);
    chk("rst_pin",   32'(p_in), 0);
    chk("rst_pin_inv", 32'(p_in_i), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven bursts, including timeout and its clearing by the next start
    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i]);
      repeat (3) @(negedge clk);
    end

    // Second start during a burst is ignored
    mode = 1;
    sbq.push_back('{24, 7, 0});
    pulse_start(1'b0);
    repeat (30) @(negedge clk);
    pulse_start(1'b0);
    chk("busy_mid_restart", 32'(busy), 1);
    wait_done(1'b0, ok);
    check_result(1'b0, ok);
    repeat (3) @(negedge clk);

    // Start presented in the DONE cycle is ignored
    mode = 0;
    sbq.push_back('{8, 2, 0});
    pulse_start(1'b0);
    wait_done(1'b0, ok);
    start = 1'b1;
    check_result(1'b0, ok);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_done_ignored", 32'(busy), 0);

    // Asynchronous reset in the middle of a WAIT
    mode = 1;
    pulse_start(1'b0);
    repeat (32) @(negedge clk);
    mode = 3;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    chk("pre_rst_sum",  32'(dsum), 7);
    chk("pre_rst_max",  32'(dmax), 7);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pin",  32'(p_in), 0);
    chk("arst_sum",  32'(dsum), 0);
    chk("arst_max",  32'(dmax), 0);
    chk("arst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    chk("arst_no_done", 32'(done), 0);
    rst_n = 1'b1;
    mode  = 0;
    repeat (2) @(negedge clk);
    chk("post_rst_done", 32'(done), 0);
    run_vec(tbl[0]);

    // Inverting chain with PATH_INV=1
    sbq.push_back('{8, 2, 0});
    pulse_start(1'b1);
    chk("inv_busy_after_start", 32'(busy_i), 1);
    wait_done(1'b1, ok);
    check_result(1'b1, ok);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
